// File: rtl/mul_pkg.sv
// Shared definitions for the RV32M multiply sequencer: opcodes, FSM states
// and the one-entry operand/result cache entry.
package mul_pkg;

  localparam int unsigned MUL_XLEN = 32;

  // Same encoding as the multiplier's opcode input (funct3[1:0]).
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [1:0]          op;
    logic [MUL_XLEN-1:0] a;
    logic [MUL_XLEN-1:0] b;
    logic [MUL_XLEN-1:0] res;
  } cache_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Bundle of E-stage request, multiplier handshake and writeback signals.
// The sequencer takes the master view; the pipeline/multiplier side takes slave.
interface mul_seq_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            mul_reqE;
  logic [1:0]      mul_opE;
  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] srcBE;
  logic [4:0]      rdE;
  logic            flushE;
  logic            mul_start;
  logic [1:0]      mul_opcode;
  logic [XLEN-1:0] mul_op1;
  logic [XLEN-1:0] mul_op2;
  logic            mul_done;
  logic [XLEN-1:0] mul_result;
  logic            stall_mul;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            timeout_err;

  modport master (
    input  mul_reqE, mul_opE, srcAE, srcBE, rdE, flushE, mul_done, mul_result,
    output mul_start, mul_opcode, mul_op1, mul_op2, stall_mul,
           wb_valid, wb_rd, wb_data, timeout_err
  );

  modport slave (
    output mul_reqE, mul_opE, srcAE, srcBE, rdE, flushE, mul_done, mul_result,
    input  mul_start, mul_opcode, mul_op1, mul_op2, stall_mul,
           wb_valid, wb_rd, wb_data, timeout_err
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// E-stage sequencer for the shared iterative multiplier: launches, stalls,
// returns results, survives flushes, caches the last result and guards hangs.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter bit          CACHE_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned XLEN           = mul_pkg::MUL_XLEN
) (
  input  logic           clk,
  input  logic           rst,
  mul_seq_ctrl_if.master bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_e          state_q, state_d;
  logic            wbValid_q, wbValid_d;
  logic [4:0]      wbRd_q, wbRd_d;
  logic [XLEN-1:0] wbData_q, wbData_d;
  logic            timeoutErr_q, timeoutErr_d;
  cache_t          cache_q, cache_d;
  logic [1:0]      flOp_q, flOp_d;
  logic [XLEN-1:0] flA_q, flA_d;
  logic [XLEN-1:0] flB_q, flB_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic mulStart;
  logic stall;
  logic newReq;
  logic cacheHit;
  logic wdExpired;

  assign newReq    = bus.mul_reqE && !bus.flushE;
  assign cacheHit  = CACHE_EN && cache_q.valid && (cache_q.op == bus.mul_opE) &&
                     (cache_q.a == bus.srcAE) && (cache_q.b == bus.srcBE);
  assign wdExpired = (wdog_q >= WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    wbRd_d       = wbRd_q;
    wbData_d     = wbData_q;
    timeoutErr_d = timeoutErr_q;
    cache_d      = cache_q;
    flOp_d       = flOp_q;
    flA_d        = flA_q;
    flB_d        = flB_q;
    wdog_d       = wdog_q;
    mulStart     = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall = newReq;
        if (newReq) begin
          wbRd_d = bus.rdE;
          if (cacheHit) begin
            wbData_d = cache_q.res;
            state_d  = RESP;
          end else begin
            mulStart = 1'b1;
            flOp_d   = bus.mul_opE;
            flA_d    = bus.srcAE;
            flB_d    = bus.srcBE;
            wdog_d   = '0;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        stall  = 1'b1;
        wdog_d = wdog_q + 1'b1;
        // A flush beats a coincident done: the result belongs to a killed instruction.
        if (bus.flushE) begin
          state_d = bus.mul_done ? IDLE : DRAIN;
        end else if (bus.mul_done) begin
          wbData_d = bus.mul_result;
          cache_d  = '{valid: 1'b1, op: flOp_q, a: flA_q, b: flB_q, res: bus.mul_result};
          state_d  = RESP;
        end else if (wdExpired) begin
          timeoutErr_d = 1'b1;
          wbData_d     = '0;
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      DRAIN: begin
        // The multiplier is still running the flushed op; hold any new request.
        stall  = newReq;
        wdog_d = wdog_q + 1'b1;
        if (bus.mul_done) begin
          state_d = IDLE;
        end else if (wdExpired) begin
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wbValid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wbValid_q    <= 1'b0;
      wbRd_q       <= '0;
      wbData_q     <= '0;
      timeoutErr_q <= 1'b0;
      cache_q      <= '0;
      flOp_q       <= '0;
      flA_q        <= '0;
      flB_q        <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      wbValid_q    <= wbValid_d;
      wbRd_q       <= wbRd_d;
      wbData_q     <= wbData_d;
      timeoutErr_q <= timeoutErr_d;
      cache_q      <= cache_d;
      flOp_q       <= flOp_d;
      flA_q        <= flA_d;
      flB_q        <= flB_d;
      wdog_q       <= wdog_d;
    end
  end

  assign bus.mul_start   = mulStart;
  assign bus.mul_opcode  = bus.mul_opE;
  assign bus.mul_op1     = bus.srcAE;
  assign bus.mul_op2     = bus.srcBE;
  assign bus.stall_mul   = stall;
  assign bus.wb_valid    = wbValid_q;
  assign bus.wb_rd       = wbRd_q;
  assign bus.wb_data     = wbData_q;
  assign bus.timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a fixed-latency multiplier model
// (done 34 cycles after start) that can be told to hang.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  localparam int MODEL_LAT = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_seq_ctrl_if #(.XLEN(32)) bus();

  mul_seq_ctrl #(
    .CACHE_EN(1'b1),
    .TIMEOUT_CYCLES(64),
    .XLEN(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int assertCount = 0;
  int failCount   = 0;
  logic [36:0] expQ[$];
  logic [36:0] monExp;

  logic        modelActive = 1'b0;
  logic        modelHang   = 1'b0;
  int          modelCnt    = 0;
  logic [31:0] modelRes    = '0;

  function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      OP_MUL:    p = {32'b0, a} * {32'b0, b};
      OP_MULH:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      OP_MULHSU: p = {{32{a[31]}}, a} * {32'b0, b};
      default:   p = {32'b0, a} * {32'b0, b};
    endcase
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: latches operands on start, pulses done MODEL_LAT cycles later.
  always @(posedge clk) begin
    if (rst) begin
      modelActive <= 1'b0;
      modelCnt    <= 0;
    end else if (bus.mul_start) begin
      modelActive <= 1'b1;
      modelCnt    <= 1;
      modelRes    <= refMul(bus.mul_opcode, bus.mul_op1, bus.mul_op2);
    end else if (modelActive) begin
      if (bus.mul_done) modelActive <= 1'b0;
      modelCnt <= modelCnt + 1;
    end
  end

  assign bus.mul_done   = modelActive && !modelHang && (modelCnt == MODEL_LAT);
  assign bus.mul_result = modelRes;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every writeback must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.wb_valid) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected wb_valid: got rd=%0d data=%0h, expected none", bus.wb_rd, bus.wb_data);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("wb_rd", {59'b0, bus.wb_rd}, {59'b0, monExp[36:32]});
        checkOutput("wb_data", {32'b0, bus.wb_data}, {32'b0, monExp[31:0]});
      end
    end
  end

  task automatic driveIdle();
    bus.mul_reqE = 1'b0;
    bus.flushE   = 1'b0;
  endtask

  task automatic driveReq(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.mul_reqE = 1'b1;
    bus.mul_opE  = op;
    bus.srcAE    = a;
    bus.srcBE    = b;
    bus.rdE      = rd;
    bus.flushE   = 1'b0;
  endtask

  // Holds the instruction in E until the stall drops, counting stall cycles and starts.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expData,
                               input int expStalls, input int expStarts, input string name);
    int stalls;
    int starts;
    bit accepted;
    stalls   = 0;
    starts   = 0;
    accepted = 1'b0;
    expQ.push_back({rd, expData});
    driveReq(op, a, b, rd);
    #1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (bus.mul_start) starts++;
      if (!bus.stall_mul) begin
        accepted = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
    end
    checkOutput({name, " accepted"}, {63'b0, accepted}, 64'd1);
    @(posedge clk);
    #1;
    driveIdle();
    checkOutput({name, " stall cycles"}, 64'(stalls), 64'(expStalls));
    checkOutput({name, " start pulses"}, 64'(starts), 64'(expStarts));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    bit sawDone;
    driveIdle();
    bus.mul_opE = '0;
    bus.srcAE   = '0;
    bus.srcBE   = '0;
    bus.rdE     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("reset mul_start", {63'b0, bus.mul_start}, 64'd0);
    checkOutput("reset stall_mul", {63'b0, bus.stall_mul}, 64'd0);
    checkOutput("reset wb_valid", {63'b0, bus.wb_valid}, 64'd0);
    checkOutput("reset wb_rd", {59'b0, bus.wb_rd}, 64'd0);
    checkOutput("reset wb_data", {32'b0, bus.wb_data}, 64'd0);
    checkOutput("reset timeout_err", {63'b0, bus.timeout_err}, 64'd0);

    $display("[TB] basic multiplies and cache");
    applyStimulus(OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 35, 1, "mul 7*6");
    applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 35, 1, "mulhu miss");
    applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1, 0, "mulhu hit");
    applyStimulus(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 35, 1, "mulh same operands");
    applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFF, 35, 1, "mulhsu");

    $display("[TB] flush during BUSY");
    driveReq(OP_MUL, 32'd3, 32'd4, 5'd6);
    #1;
    checkOutput("flush launch start", {63'b0, bus.mul_start}, 64'd1);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("flush busy stall", {63'b0, bus.stall_mul}, 64'd1);
    bus.flushE   = 1'b1;
    bus.mul_reqE = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("flush state drain", {62'b0, dut.state_q}, {62'b0, DRAIN});
    applyStimulus(OP_MUL, 32'd2, 32'd5, 5'd7, 32'd10, 59, 1, "mul 2*5 after flush");
    applyStimulus(OP_MUL, 32'd2, 32'd5, 5'd7, 32'd10, 1, 0, "mul 2*5 cached");
    applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd6, 32'd12, 35, 1, "mul 3*4 not cached");

    $display("[TB] done and flush together");
    driveReq(OP_MUL, 32'd9, 32'd9, 5'd8);
    sawDone = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (bus.mul_done) begin
        sawDone = 1'b1;
        break;
      end
    end
    checkOutput("done seen before flush", {63'b0, sawDone}, 64'd1);
    bus.flushE   = 1'b1;
    bus.mul_reqE = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("done+flush state idle", {62'b0, dut.state_q}, {62'b0, IDLE});
    checkOutput("done+flush wb_valid", {63'b0, bus.wb_valid}, 64'd0);
    driveIdle();
    applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd6, 32'd12, 1, 0, "cache kept 3*4");
    applyStimulus(OP_MUL, 32'd9, 32'd9, 5'd8, 32'd81, 35, 1, "mul 9*9 relaunch");

    $display("[TB] watchdog");
    modelHang = 1'b1;
    applyStimulus(OP_MULHU, 32'd5, 32'd5, 5'd9, 32'd0, 65, 1, "hung mulhu");
    checkOutput("timeout_err set", {63'b0, bus.timeout_err}, 64'd1);
    modelHang = 1'b0;
    applyStimulus(OP_MUL, 32'd2, 32'd3, 5'd10, 32'd6, 35, 1, "mul after timeout");
    checkOutput("timeout_err sticky", {63'b0, bus.timeout_err}, 64'd1);

    $display("[TB] reset during BUSY");
    driveReq(OP_MUL, 32'd4, 32'd4, 5'd12);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    driveIdle();
    @(posedge clk);
    #1;
    checkOutput("mid reset state", {62'b0, dut.state_q}, {62'b0, IDLE});
    checkOutput("mid reset stall_mul", {63'b0, bus.stall_mul}, 64'd0);
    checkOutput("mid reset wb_valid", {63'b0, bus.wb_valid}, 64'd0);
    checkOutput("mid reset wb_rd", {59'b0, bus.wb_rd}, 64'd0);
    checkOutput("mid reset wb_data", {32'b0, bus.wb_data}, 64'd0);
    checkOutput("mid reset timeout_err", {63'b0, bus.timeout_err}, 64'd0);
    checkOutput("mid reset cache valid", {63'b0, dut.cache_q.valid}, 64'd0);
    rst = 1'b0;
    applyStimulus(OP_MUL, 32'd2, 32'd3, 5'd10, 32'd6, 35, 1, "repeat 2*3 after reset");
    applyStimulus(OP_MUL, 32'd4, 32'd4, 5'd12, 32'd16, 35, 1, "mul 4*4 after reset");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
